pwm_dac_ctrl: RTL and testbench
===============================

# pwm_dac_ctrl

Sample sequencer in front of the PWM DAC digital part. It buffers duty-cycle samples from a producer over a valid/ready handshake and drives the DAC's `set_i`. `set_o` changes only on PWM period boundaries, so no period carries a mixed duty cycle. Each sample is held for a programmable number of periods, and the block flags underruns.

## Interface
Parameters:
- `WIDTH`, 4: sample / duty-cycle width. The PWM period is 2^WIDTH cycles and must match the DAC.
- `DEPTH`, 4: sample FIFO depth. Must be a power of two, ≥2.

Ports:
- `clk_i`  in  1  clock, shared with the DAC.
- `rst_ni`  in  1  reset, asynchronous, active-low; shared with the DAC.
- `en_i`  in  1  playback enable.
- `hold_i`  in  4  periods per sample minus 1 (0 means 1 period, 15 means 16 periods).
- `sample_i`  in  WIDTH  duty-cycle sample.
- `sample_valid_i`  in  1  producer has a sample.
- `sample_ready_o`  out  1  FIFO can accept a sample.
- `set_o`  out  WIDTH  duty cycle to DAC `set_i`.
- `period_start_o`  out  1  high in the last cycle of each PWM period.
- `underrun_o`  out  1  sticky underrun flag.
- `clr_underrun_i`  in  1  clears `underrun_o`.
- `level_o`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Phase counter:** WIDTH bits.
  - Resets to 0 and increments every cycle, wrapping at 2^WIDTH−1 to 0.
  - Runs regardless of `en_i`, so it mirrors the DAC counter exactly.
  - A boundary is the cycle with phase == 2^WIDTH−1; `period_start_o` = boundary.
- **FIFO:** DEPTH entries, registered storage.
  - `sample_ready_o` = !full.
  - Push on `sample_valid_i && sample_ready_o`.
  - A pop occurs only on a boundary load (see FSM).
  - A pop and a push in the same cycle are both honoured; level is unchanged.
  - A push into an empty FIFO is not poppable in the same cycle.
  - The full condition blocks the push even if a pop occurs that cycle.
- **Hold counter:** 4 bits.
  - Cleared and `hold_q` ← `hold_i` on every load.
  - Increments on each boundary without a load.
  - "Hold done" = hold_cnt == hold_q.
- **FSM states:** IDLE, RUN, UNDERRUN. All transitions are evaluated on boundary cycles only and take effect at the following edge (phase wraps to 0).
  - **IDLE** (`set_o` = 0):
    - `en_i` && non-empty → pop, load `set_o`, go to RUN.
    - Otherwise stay in IDLE, with no underrun.
  - **RUN:**
    - `!en_i` → IDLE, `set_o` ← 0. This applies even if the hold is not done. The FIFO is retained.
    - Hold done && non-empty → pop, load, stay in RUN.
    - Hold done && empty → UNDERRUN, set `underrun_o`, keep `set_o`.
    - Hold not done → hold counter +1.
  - **UNDERRUN** (`set_o` keeps the last sample):
    - `!en_i` → IDLE, `set_o` ← 0.
    - Non-empty → pop, load, go to RUN.
    - Otherwise stay in UNDERRUN; the flag stays set.
- **Underrun flag:**
  - `clr_underrun_i` clears it at the next edge.
  - A set in the same cycle wins over the clear.

## Timing
- **Reset values:**
  - `set_o` = 0, `period_start_o` = 0 (phase 0), `underrun_o` = 0, `level_o` = 0, `sample_ready_o` = 1.
  - FSM = IDLE, FIFO empty, hold counter and `hold_q` = 0.
- **Mid-operation reset:**
  - Immediate, asynchronous return to reset values.
  - The FIFO is flushed.
- **Boundary loads:**
  - `set_o` updates on the edge after `period_start_o`, i.e. it is valid from the cycle in which DAC counter == 0.
  - It is constant for whole periods.
- **Latency:**
  - A sample pushed into an empty FIFO while enabled appears on `set_o` at the first boundary load at least 1 cycle after the push.
  - Worst case is 2^WIDTH cycles.
- `level_o` updates the cycle after a push or pop.
- `sample_ready_o` is combinational from the FIFO state only. It never depends on `sample_valid_i`.

## Test plan
- **Basic playback:** reset; push 3, 7, 12 with `hold_i` = 0, `en_i` = 1.
  - `set_o` = 3, 7, 12 in consecutive 16-cycle periods, each starting at phase 0.
  - Then UNDERRUN, with `set_o` held at 12 and `underrun_o` = 1.
- **Hold count:** `hold_i` = 2, push 5 then 9.
  - `set_o` = 5 for exactly 48 cycles, then 9.
- **Backpressure:** DEPTH = 4, `en_i` = 0; push 5 samples back-to-back.
  - 4 are accepted and `level_o` = 4.
  - `sample_ready_o` = 0 while `sample_valid_i` is held.
  - Enable: the first boundary pop raises ready the next cycle and the 5th sample is accepted.
- **Enable drop mid-hold:** `hold_i` = 3, playing 10; drop `en_i` at phase 5 of the second period.
  - `set_o` goes to 0 at the next phase 0.
  - The FIFO is unchanged.
  - Re-enable: the next FIFO sample loads at the following boundary.
- **Underrun clear race:** in UNDERRUN, assert `clr_underrun_i` on a boundary cycle while the FIFO is still empty.
  - `underrun_o` stays 1 (set wins).
  - A later clear with a sample pushed gives `underrun_o` = 0 and RUN.
- **Async reset mid-run:** pull `rst_ni` low at phase 9 with 3 samples queued.
  - All outputs go to reset values immediately.
  - `level_o` = 0; after release, the phase restarts at 0 in lockstep with the DAC.

Source files
------------

// File: rtl/pwm_dac_ctrl.sv
// pwm_dac_ctrl
// Sample sequencer in front of the PWM DAC. Buffers duty-cycle samples from a
// producer (valid/ready) and presents them on set_o, changing only on PWM
// period boundaries. Each sample is held for hold_i+1 periods. Underruns are
// flagged with a sticky bit.
//
// Ports
//   clk_i            clock, shared with the DAC
//   rst_ni           asynchronous active-low reset, shared with the DAC
//   en_i             playback enable
//   hold_i           periods per sample minus 1
//   sample_i         duty-cycle sample from producer
//   sample_valid_i   producer has a sample
//   sample_ready_o   FIFO can accept a sample
//   set_o            duty cycle to DAC set_i
//   period_start_o   high in the last cycle of each PWM period
//   underrun_o       sticky underrun flag
//   clr_underrun_i   clears underrun_o (a simultaneous set wins)
//   level_o          FIFO occupancy
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | playback stopped, set_o forced to 0
// ST_RUN      | playing a sample, counting hold periods
// ST_UNDERRUN | FIFO ran dry, last sample repeated, flag set

module pwm_dac_ctrl #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       en_i,
   input  logic [3:0]                 hold_i,
   input  logic [WIDTH-1:0]           sample_i,
   input  logic                       sample_valid_i,
   output logic                       sample_ready_o,
   output logic [WIDTH-1:0]           set_o,
   output logic                       period_start_o,
   output logic                       underrun_o,
   input  logic                       clr_underrun_i,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_UNDERRUN = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] phase_q, phase_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic [WIDTH-1:0] set_q, set_d;
   logic [3:0]       hold_q, hold_d;
   logic [3:0]       hold_cnt_q, hold_cnt_d;
   logic             underrun_q, underrun_d;

   logic boundary;
   logic full;
   logic empty;
   logic push;
   logic load;
   logic underrun_set;
   logic hold_done;

   assign boundary  = &phase_q;
   assign full      = (level_q == (AW+1)'(DEPTH));
   assign empty     = (level_q == '0);
   assign push      = sample_valid_i && !full;
   assign hold_done = (hold_cnt_q == hold_q);

   assign sample_ready_o = !full;
   assign set_o          = set_q;
   assign period_start_o = boundary;
   assign underrun_o     = underrun_q;
   assign level_o        = level_q;

   // Phase mirrors the DAC counter, so it free-runs regardless of en_i.
   assign phase_d = phase_q + WIDTH'(1);

   always_comb begin
      state_d      = state_q;
      set_d        = set_q;
      hold_d       = hold_q;
      hold_cnt_d   = hold_cnt_q;
      load         = 1'b0;
      underrun_set = 1'b0;

      if (boundary) begin
         case (state_q)
            ST_IDLE: begin
               if (en_i && !empty) load = 1'b1;
            end
            ST_RUN: begin
               if (!en_i) begin
                  state_d = ST_IDLE;
                  set_d   = '0;
               end else if (!hold_done) begin
                  hold_cnt_d = hold_cnt_q + 4'd1;
               end else if (!empty) begin
                  load = 1'b1;
               end else begin
                  state_d      = ST_UNDERRUN;
                  underrun_set = 1'b1;
               end
            end
            ST_UNDERRUN: begin
               if (!en_i) begin
                  state_d = ST_IDLE;
                  set_d   = '0;
               end else if (!empty) begin
                  load = 1'b1;
               end else begin
                  // Re-asserting the set each starved boundary lets it beat a clear.
                  underrun_set = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               set_d   = '0;
            end
         endcase
      end

      if (load) begin
         state_d    = ST_RUN;
         set_d      = mem_q[rd_ptr_q];
         hold_d     = hold_i;
         hold_cnt_d = 4'd0;
      end
   end

   // FIFO: the pop reads the head before this cycle's push lands, so a sample
   // pushed into an empty FIFO cannot be popped in the same cycle.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = sample_i;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (load) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, load})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      underrun_d = underrun_q;
      if (underrun_set)        underrun_d = 1'b1;
      else if (clr_underrun_i) underrun_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         phase_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         set_q      <= '0;
         hold_q     <= 4'd0;
         hold_cnt_q <= 4'd0;
         underrun_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         set_q      <= set_d;
         hold_q     <= hold_d;
         hold_cnt_q <= hold_cnt_d;
         underrun_q <= underrun_d;
         mem_q      <= mem_d;
      end
   end

endmodule

// File: tb/tb_pwm_dac_ctrl.sv
// Randomized bench for pwm_dac_ctrl against a period-level reference model.
module tb_pwm_dac_ctrl;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int PER   = 16;
   localparam int N_CYC = 6000;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             en_i;
   logic [3:0]       hold_i;
   logic [WIDTH-1:0] sample_i;
   logic             sample_valid_i;
   logic             sample_ready_o;
   logic [WIDTH-1:0] set_o;
   logic             period_start_o;
   logic             underrun_o;
   logic             clr_underrun_i;
   logic [2:0]       level_o;

   pwm_dac_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .en_i           (en_i),
      .hold_i         (hold_i),
      .sample_i       (sample_i),
      .sample_valid_i (sample_valid_i),
      .sample_ready_o (sample_ready_o),
      .set_o          (set_o),
      .period_start_o (period_start_o),
      .underrun_o     (underrun_o),
      .clr_underrun_i (clr_underrun_i),
      .level_o        (level_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: periods are whole units; a playing sample has a number
   // of extra periods still to go; mode 0 = stopped, 1 = playing, 2 = starved.
   int m_phase;
   int m_q[$];
   int m_mode;
   int m_set;
   int m_left;
   bit m_flag;

   int valid_pct;
   int hold_sel;

   task automatic model_reset();
      m_phase = 0;
      m_q.delete();
      m_mode  = 0;
      m_set   = 0;
      m_left  = 0;
      m_flag  = 1'b0;
   endtask

   task automatic check_reset_values(input string pfx);
      chk({pfx, "_set"},      32'(set_o),          32'd0);
      chk({pfx, "_pstart"},   32'(period_start_o), 32'd0);
      chk({pfx, "_underrun"}, 32'(underrun_o),     32'd0);
      chk({pfx, "_level"},    32'(level_o),        32'd0);
      chk({pfx, "_ready"},    32'(sample_ready_o), 32'd1);
   endtask

   task automatic model_step();
      bit boundary, push, load, uset;
      int size;
      boundary = (m_phase == PER - 1);
      size     = m_q.size();
      push     = sample_valid_i && (size < DEPTH);
      load     = 1'b0;
      uset     = 1'b0;
      if (boundary) begin
         if (m_mode == 0) begin
            if (en_i && size > 0) load = 1'b1;
         end else if (!en_i) begin
            m_mode = 0;
            m_set  = 0;
         end else if (m_mode == 1 && m_left > 0) begin
            m_left--;
         end else if (size > 0) begin
            load = 1'b1;
         end else begin
            m_mode = 2;
            uset   = 1'b1;
         end
      end
      if (load) begin
         m_set  = m_q.pop_front();
         m_left = int'(hold_i);
         m_mode = 1;
      end
      if (push) m_q.push_back(int'(sample_i));
      if (uset) m_flag = 1'b1;
      else if (clr_underrun_i) m_flag = 1'b0;
      m_phase = (m_phase + 1) % PER;
   endtask

   task automatic cycle_body();
      chk("set",      32'(set_o),          32'(m_set));
      chk("pstart",   32'(period_start_o), 32'(m_phase == PER - 1));
      chk("underrun", 32'(underrun_o),     32'(m_flag));
      chk("level",    32'(level_o),        32'(m_q.size()));
      chk("ready",    32'(sample_ready_o), 32'(m_q.size() < DEPTH));
      sample_valid_i = ($urandom_range(99) < valid_pct);
      sample_i       = WIDTH'($urandom_range(PER - 1));
      hold_i         = 4'(hold_sel);
      clr_underrun_i = ($urandom_range(99) < 4);
      if ($urandom_range(149) == 0) en_i = ~en_i;
      model_step();
   endtask

   // Entered on a falling edge; leaves rst_ni released on a later falling edge.
   task automatic apply_reset();
      #2 rst_ni = 1'b0;
      #1 check_reset_values("arst");
      model_reset();
      @(negedge clk_i);
      check_reset_values("arst_hold");
      rst_ni = 1'b1;
   endtask

   initial begin
      rst_ni         = 1'b0;
      en_i           = 1'b1;
      hold_i         = 4'd0;
      sample_i       = '0;
      sample_valid_i = 1'b0;
      clr_underrun_i = 1'b0;
      valid_pct      = 20;
      hold_sel       = 0;
      model_reset();
      repeat (2) @(negedge clk_i);
      check_reset_values("por");
      rst_ni = 1'b1;
      for (int c = 0; c < N_CYC; c++) begin
         if (c > 0) @(negedge clk_i);
         if (c % 128 == 0) begin
            case ($urandom_range(3))
               0: valid_pct = 3;
               1: valid_pct = 10;
               2: valid_pct = 40;
               default: valid_pct = 95;
            endcase
            hold_sel = ($urandom_range(4) == 0) ? int'($urandom_range(15)) : int'($urandom_range(3));
         end
         if (c % 1500 == 777 + (c / 1500) * 0) apply_reset();
         cycle_body();
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
